// File: rtl/im_fetch_mem_if.sv
// Fetch/load bus of the writable instruction store: PC request side plus program-load port.
interface im_fetch_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LOAD_AW = 6
);
  logic [ADDR_W-1:0]  PC_in;
  logic               req;
  logic               stall;
  logic               load_en;
  logic [LOAD_AW-1:0] load_addr;
  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  instruction;
  logic               instr_valid;
  logic               fault;

  modport master (
    output PC_in, req, stall, load_en, load_addr, load_data,
    input  instruction, instr_valid, fault
  );

  modport slave (
    input  PC_in, req, stall, load_en, load_addr, load_data,
    output instruction, instr_valid, fault
  );
endinterface

// File: rtl/im_fetch_mem.sv
// Writable word-addressed instruction store read by byte PC, with 1- or 2-cycle read
// pipeline, stall hold and misaligned/out-of-range fault reporting.
module im_fetch_mem #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter int                DEPTH   = 64,
  parameter int                LATENCY = 1,
  parameter logic [DATA_W-1:0] NOP     = '0
) (
  input  logic           clk,
  input  logic           rst,
  im_fetch_mem_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_W - 2;

  generate
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("im_fetch_mem: LATENCY must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("im_fetch_mem: DEPTH must be at least 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [WW-1:0]     widx;
  logic              misaligned;
  logic              oor;
  logic              bad;
  logic              accept;
  logic [AW-1:0]     ridx;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    widx       = bus.PC_in[ADDR_W-1:2];
    misaligned = |bus.PC_in[1:0];
    oor        = ({32'd0, widx} >= (WW+32)'(DEPTH));
    bad        = misaligned | oor;
    accept     = bus.req & ~bus.stall & ~rst;
    // Out-of-range indices are steered to word 0 so the array is never addressed past DEPTH.
    ridx       = oor ? '0 : widx[AW-1:0];
    rd_word    = mem[ridx];
  end

  // Program load: independent of reset, stall and fetch traffic; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && ({1'b0, bus.load_addr} < (AW+1)'(DEPTH))) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // ---- stage 1: array read (read-first against a same-edge load) ----
  logic              vld_p1;
  logic              flt_p1;
  logic [DATA_W-1:0] dat_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      flt_p1 <= 1'b0;
      dat_p1 <= NOP;
    end else if (!bus.stall) begin
      vld_p1 <= accept;
      flt_p1 <= accept & bad;
      dat_p1 <= (accept && !bad) ? rd_word : NOP;
    end
  end

  // ---- stage 2: optional output register ----
  generate
    if (LATENCY == 2) begin : g_lat2
      logic              vld_p2;
      logic              flt_p2;
      logic [DATA_W-1:0] dat_p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2 <= 1'b0;
          flt_p2 <= 1'b0;
          dat_p2 <= NOP;
        end else if (!bus.stall) begin
          vld_p2 <= vld_p1;
          flt_p2 <= flt_p1;
          dat_p2 <= dat_p1;
        end
      end

      assign bus.instr_valid = vld_p2;
      assign bus.fault       = flt_p2;
      assign bus.instruction = dat_p2;
    end else begin : g_lat1
      assign bus.instr_valid = vld_p1;
      assign bus.fault       = flt_p1;
      assign bus.instruction = dat_p1;
    end
  endgenerate

endmodule

// File: tb/tb_im_fetch_mem.sv
// Directed bench for im_fetch_mem: one LATENCY=1 and one LATENCY=2 instance share stimulus.
module tb_im_fetch_mem;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  im_fetch_mem_if #(.DATA_W(32), .ADDR_W(32), .LOAD_AW(6)) if1 ();
  im_fetch_mem_if #(.DATA_W(32), .ADDR_W(32), .LOAD_AW(6)) if2 ();

  im_fetch_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1), .NOP(32'd0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  im_fetch_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(2), .NOP(32'd0)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  always #5 clk = ~clk;

  // Expected response packed as {instr_valid, fault, instruction}
  typedef struct packed {
    logic        rst;
    logic        req;
    logic        stall;
    logic [31:0] pc;
    logic        le;
    logic [5:0]  la;
    logic [31:0] ld;
    logic [33:0] e1;
    logic [33:0] e2;
  } row_t;

  localparam logic [33:0] B = 34'h0;
  localparam logic [33:0] F = {2'b11, 32'h0};
  localparam logic [31:0] M0 = 32'h0022_1000, M1 = 32'h0064_2000;
  localparam logic [31:0] M2 = 32'h00A6_3000, M3 = 32'h0128_4000;
  localparam logic [31:0] M63 = 32'hDEAD_BEEF, M5A = 32'hAAAA_0000, M5B = 32'h5555_FFFF;
  localparam logic [31:0] M7 = 32'h1234_5678;

  function automatic logic [33:0] V(input logic [31:0] d);
    return {2'b10, d};
  endfunction

  function automatic row_t mk(input int rs, input int rq, input int st, input logic [31:0] pc,
                              input int le, input int la, input logic [31:0] ld,
                              input logic [33:0] e1, input logic [33:0] e2);
    row_t r;
    r.rst = (rs != 0); r.req = (rq != 0); r.stall = (st != 0); r.pc = pc;
    r.le = (le != 0); r.la = la[5:0]; r.ld = ld; r.e1 = e1; r.e2 = e2;
    return r;
  endfunction

  function automatic logic [33:0] o1();
    return {if1.instr_valid, if1.fault, if1.instruction};
  endfunction

  function automatic logic [33:0] o2();
    return {if2.instr_valid, if2.fault, if2.instruction};
  endfunction

  task automatic drive(input row_t r);
    rst           = r.rst;
    if1.req       = r.req;   if2.req       = r.req;
    if1.stall     = r.stall; if2.stall     = r.stall;
    if1.PC_in     = r.pc;    if2.PC_in     = r.pc;
    if1.load_en   = r.le;    if2.load_en   = r.le;
    if1.load_addr = r.la;    if2.load_addr = r.la;
    if1.load_data = r.ld;    if2.load_data = r.ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t t[$];
    t.push_back(mk(1, 0, 0, 32'd0, 0, 0, 32'h0, B, B));
    t.push_back(mk(1, 1, 0, 32'd0, 0, 0, 32'h0, B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 0, 0, 32'h0, B, B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL reset row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL reset row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  task automatic test_load_read();
    row_t t[$];
    t.push_back(mk(0, 0, 0, 32'd0, 1, 0,  M0,  B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 1, 1,  M1,  B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 1, 2,  M2,  B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 1, 3,  M3,  B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 1, 63, M63, B, B));
    t.push_back(mk(0, 0, 0, 32'd0, 1, 5,  M5A, B, B));
    t.push_back(mk(0, 1, 0, 32'd0,  0, 0, 32'h0, V(M0), B));
    t.push_back(mk(0, 1, 0, 32'd4,  0, 0, 32'h0, V(M1), V(M0)));
    t.push_back(mk(0, 1, 0, 32'd8,  0, 0, 32'h0, V(M2), V(M1)));
    t.push_back(mk(0, 1, 0, 32'd12, 0, 0, 32'h0, V(M3), V(M2)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     V(M3)));
    t.push_back(mk(0, 1, 0, 32'd0,  0, 0, 32'h0, V(M0), B));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     V(M0)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL load_read row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL load_read row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  task automatic test_faults();
    row_t t[$];
    t.push_back(mk(0, 1, 0, 32'd6,   0, 0, 32'h0, F,      B));
    t.push_back(mk(0, 1, 0, 32'd256, 0, 0, 32'h0, F,      F));
    t.push_back(mk(0, 1, 0, 32'd252, 0, 0, 32'h0, V(M63), F));
    t.push_back(mk(0, 0, 0, 32'd0,   0, 0, 32'h0, B,      V(M63)));
    t.push_back(mk(0, 0, 0, 32'd0,   0, 0, 32'h0, B,      B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL faults row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL faults row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  task automatic test_stall();
    row_t t[$];
    t.push_back(mk(0, 1, 0, 32'd0, 0, 0, 32'h0, V(M0), B));
    t.push_back(mk(0, 1, 0, 32'd4, 0, 0, 32'h0, V(M1), V(M0)));
    t.push_back(mk(0, 1, 1, 32'd8, 0, 0, 32'h0, V(M1), V(M0)));
    t.push_back(mk(0, 1, 1, 32'd8, 0, 0, 32'h0, V(M1), V(M0)));
    t.push_back(mk(0, 1, 1, 32'd8, 0, 0, 32'h0, V(M1), V(M0)));
    t.push_back(mk(0, 0, 0, 32'd0, 0, 0, 32'h0, B,     V(M1)));
    t.push_back(mk(0, 0, 0, 32'd0, 0, 0, 32'h0, B,     B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL stall row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL stall row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  task automatic test_collision();
    row_t t[$];
    t.push_back(mk(0, 1, 0, 32'd20, 1, 5, M5B,   V(M5A), B));
    t.push_back(mk(0, 1, 0, 32'd20, 0, 0, 32'h0, V(M5B), V(M5A)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,      V(M5B)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,      B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL collision row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL collision row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  task automatic test_reset_midflight();
    row_t t[$];
    t.push_back(mk(0, 1, 0, 32'd0,  0, 0, 32'h0, V(M0), B));
    t.push_back(mk(0, 1, 0, 32'd4,  0, 0, 32'h0, V(M1), V(M0)));
    // reset with stall high and a load on the same edge
    t.push_back(mk(1, 1, 1, 32'd8,  1, 7, M7,    B,     B));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     B));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     B));
    t.push_back(mk(0, 1, 0, 32'd12, 0, 0, 32'h0, V(M3), B));
    t.push_back(mk(0, 1, 0, 32'd28, 0, 0, 32'h0, V(M7), V(M3)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     V(M7)));
    t.push_back(mk(0, 0, 0, 32'd0,  0, 0, 32'h0, B,     B));
    foreach (t[i]) begin
      drive(t[i]); step();
      total++;
      if (o1() !== t[i].e1) begin bad++; $display("FAIL rst_midflight row%0d lat1 got=%h want=%h", i, o1(), t[i].e1); end
      total++;
      if (o2() !== t[i].e2) begin bad++; $display("FAIL rst_midflight row%0d lat2 got=%h want=%h", i, o2(), t[i].e2); end
    end
  endtask

  initial begin
    drive(mk(1, 0, 0, 32'd0, 0, 0, 32'h0, B, B));
    test_reset();
    test_load_read();
    test_faults();
    test_stall();
    test_collision();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
